// File: rtl/imm_gen_queue.sv
// Immediate generator with a FIFO_DEPTH-entry output queue and valid/ready handshakes on both sides.
// Optional per-entry error flag (imm_src 000/111) enabled by defining IMMGEN_ERR_CHECK_EN.
module imm_gen_queue #(
  parameter int XLEN       = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [31:0]                   instruction,
  input  logic [2:0]                    imm_src,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [XLEN-1:0]               immediate,
  output logic [2:0]                    out_fmt,
  output logic [$clog2(FIFO_DEPTH):0]   count
`ifdef IMMGEN_ERR_CHECK_EN
  ,
  output logic                          out_err
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Extract the format's immediate as a 32-bit signed value, then sign-extend to XLEN.
  function automatic logic signed [XLEN-1:0] ext_imm(input logic [31:7] ins,
                                                     input logic [2:0]  src);
    logic signed [31:0] t;
    t = '0;
    case (src)
      3'b001:  t = {{20{ins[31]}}, ins[31:20]};
      3'b010:  t = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      3'b011:  t = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      3'b100:  t = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      3'b101:  t = {ins[31:12], 12'b0};
      3'b110:  t = {27'b0, ins[19:15]};
      default: t = '0;
    endcase
    return XLEN'(t);
  endfunction

  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [CNT_W-1:0]        count_q;
  logic                    rdy_q;

  logic signed [XLEN-1:0]  mem_imm [FIFO_DEPTH];
  logic [2:0]              mem_fmt [FIFO_DEPTH];
`ifdef IMMGEN_ERR_CHECK_EN
  logic                    mem_err [FIFO_DEPTH];
  logic                    err_p0;
`endif

  logic signed [XLEN-1:0]  imm_p0;
  logic                    push_p0;
  logic                    pop_p0;
  logic                    unused_opcode;

  // p0: decode and handshake; opcode bits never contribute to any immediate
  assign unused_opcode = ^instruction[6:0];
  assign imm_p0        = ext_imm(instruction[31:7], imm_src);
`ifdef IMMGEN_ERR_CHECK_EN
  assign err_p0        = (imm_src == 3'b000) || (imm_src == 3'b111);
`endif

  // rdy_q keeps in_ready low during reset and for the edge that releases it
  assign in_ready  = rdy_q && (count_q != CNT_W'(FIFO_DEPTH));
  assign out_valid = (count_q != '0);
  assign push_p0   = in_valid && in_ready;
  assign pop_p0    = out_valid && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      rdy_q   <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      if (push_p0) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_p0) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push_p0, pop_p0})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // p1: queue storage, data path only
  always_ff @(posedge clk) begin
    if (push_p0) begin
      mem_imm[wr_ptr] <= imm_p0;
      mem_fmt[wr_ptr] <= imm_src;
`ifdef IMMGEN_ERR_CHECK_EN
      mem_err[wr_ptr] <= err_p0;
`endif
    end
  end

  // Head outputs are forced to zero when empty so no stale entry leaks out
  assign immediate = out_valid ? mem_imm[rd_ptr] : '0;
  assign out_fmt   = out_valid ? mem_fmt[rd_ptr] : 3'b000;
  assign count     = count_q;
`ifdef IMMGEN_ERR_CHECK_EN
  assign out_err   = out_valid ? mem_err[rd_ptr] : 1'b0;
`endif

endmodule

// File: tb/tb_imm_gen_queue.sv
// Bench for imm_gen_queue: XLEN=32 and XLEN=64 instances driven in lockstep against a queue model.
// Out_err checks compile in only when IMMGEN_ERR_CHECK_EN is defined.
module tb_imm_gen_queue;

  localparam int DEPTH = 2;

  logic        clk, reset, in_valid, out_ready;
  logic [31:0] instruction;
  logic [2:0]  imm_src;
  logic        rdy32, rdy64, v32, v64;
  logic [31:0] imm32;
  logic [63:0] imm64;
  logic [2:0]  fmt32, fmt64;
  logic [1:0]  cnt32, cnt64;
`ifdef IMMGEN_ERR_CHECK_EN
  logic        err32, err64;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        err;
  } ent_t;

  ent_t mq[$];
  bit   mrdy = 1'b0;

  imm_gen_queue #(.XLEN(32), .FIFO_DEPTH(DEPTH)) dut32 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy32),
    .instruction(instruction), .imm_src(imm_src), .out_valid(v32),
    .out_ready(out_ready), .immediate(imm32), .out_fmt(fmt32), .count(cnt32)
`ifdef IMMGEN_ERR_CHECK_EN
    , .out_err(err32)
`endif
  );

  imm_gen_queue #(.XLEN(64), .FIFO_DEPTH(DEPTH)) dut64 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy64),
    .instruction(instruction), .imm_src(imm_src), .out_valid(v64),
    .out_ready(out_ready), .immediate(imm64), .out_fmt(fmt64), .count(cnt64)
`ifdef IMMGEN_ERR_CHECK_EN
    , .out_err(err64)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic longint sx(input longint val, input int bits);
    if (val >= (longint'(1) << (bits - 1))) return val - (longint'(1) << bits);
    return val;
  endfunction

  // Reference immediate computed arithmetically from the field layout, 64-bit result
  function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [2:0] src);
    longint v;
    case (src)
      3'd1: v = sx(longint'(ins[31:20]), 12);
      3'd2: v = sx(longint'(ins[31:25]) * 32 + longint'(ins[11:7]), 12);
      3'd3: v = sx(longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048 +
                   longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2, 13);
      3'd4: v = sx(longint'(ins[31]) * 1048576 + longint'(ins[19:12]) * 4096 +
                   longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2, 21);
      3'd5: v = sx(longint'(ins[31:12]) * 4096, 32);
      3'd6: v = longint'(ins[19:15]);
      default: v = 0;
    endcase
    return 64'(v);
  endfunction

  function automatic logic [63:0] e_imm();
    return (mq.size() != 0) ? mq[0].imm : 64'd0;
  endfunction

  function automatic logic [2:0] e_fmt();
    return (mq.size() != 0) ? mq[0].fmt : 3'd0;
  endfunction

  task automatic tick();
    bit   p, o;
    ent_t e;
    p = in_valid && mrdy && (mq.size() != DEPTH);
    o = out_ready && (mq.size() != 0);
    e.imm = ref_imm(instruction, imm_src);
    e.fmt = imm_src;
    e.err = (imm_src == 3'd0) || (imm_src == 3'd7);
    @(posedge clk);
    if (o) void'(mq.pop_front());
    if (p) mq.push_back(e);
    if (!reset) mrdy = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    instruction = '0; imm_src = '0;
    mq.delete(); mrdy = 1'b0;
    #1;
    n_checks++;
    if (v32 !== 1'b0 || v64 !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid got %b/%b exp 0", v32, v64);
    end
    n_checks++;
    if (cnt32 !== 2'd0 || imm32 !== 32'd0 || imm64 !== 64'd0 || fmt32 !== 3'd0) begin
      n_fail++; $display("FAIL reset_outputs cnt %0d imm %h/%h fmt %0d exp zeros", cnt32, imm32, imm64, fmt32);
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (rdy32 !== 1'b0 || rdy64 !== 1'b0) begin
      n_fail++; $display("FAIL reset_in_ready_held got %b/%b exp 0", rdy32, rdy64);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (rdy32 !== 1'b0) begin
      n_fail++; $display("FAIL reset_release_in_ready got %b exp 0", rdy32);
    end
    @(negedge clk);
    tick();
    n_checks++;
    if (rdy32 !== 1'b1 || rdy64 !== 1'b1) begin
      n_fail++; $display("FAIL post_reset_in_ready got %b/%b exp 1", rdy32, rdy64);
    end
  endtask

  task automatic test_directed();
    logic [31:0] ti [5] = '{32'hFFF00093, 32'h80000037, 32'h12345037, 32'hFE000EE3, 32'h0000D073};
    logic [2:0]  ts [5] = '{3'b001, 3'b101, 3'b101, 3'b011, 3'b110};
    logic [63:0] te [5] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFF80000000, 64'h0000000012345000,
                            64'hFFFFFFFFFFFFFFFC, 64'h0000000000000001};
    for (int i = 0; i < 5; i++) begin
      instruction = ti[i]; imm_src = ts[i]; in_valid = 1'b1; out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      n_checks++;
      if (v32 !== 1'b1 || imm64 !== te[i] || imm32 !== te[i][31:0] || fmt32 !== ts[i] || fmt64 !== ts[i]) begin
        n_fail++;
        $display("FAIL directed_%0d v %b imm %h/%h fmt %0d exp imm %h fmt %0d",
                 i, v32, imm32, imm64, fmt32, te[i], ts[i]);
      end
      n_checks++;
      if (imm64 !== e_imm()) begin
        n_fail++; $display("FAIL directed_model_%0d got %h exp %h", i, imm64, e_imm());
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b, c;
    a = $urandom; b = $urandom; c = $urandom;
    out_ready = 1'b0; in_valid = 1'b1; imm_src = 3'd1;
    instruction = a; tick();
    instruction = b; imm_src = 3'd2; tick();
    instruction = c; imm_src = 3'd4;
    n_checks++;
    if (cnt32 !== 2'd2 || rdy32 !== 1'b0 || rdy64 !== 1'b0) begin
      n_fail++; $display("FAIL b2b_full count %0d in_ready %b exp 2/0", cnt32, rdy32);
    end
    tick();
    n_checks++;
    if (cnt32 !== 2'd2 || imm32 !== ref_imm(a, 3'd1)[31:0]) begin
      n_fail++; $display("FAIL b2b_stall count %0d head %h exp 2 %h", cnt32, imm32, ref_imm(a, 3'd1));
    end
    out_ready = 1'b1;
    tick();
    n_checks++;
    if (cnt32 !== 2'd1 || rdy32 !== 1'b1 || imm64 !== ref_imm(b, 3'd2) || fmt32 !== 3'd2) begin
      n_fail++; $display("FAIL b2b_pop_a count %0d rdy %b head %h exp 1 1 %h", cnt32, rdy32, imm64, ref_imm(b, 3'd2));
    end
    tick();
    n_checks++;
    if (cnt32 !== 2'd1 || imm64 !== ref_imm(c, 3'd4) || fmt64 !== 3'd4) begin
      n_fail++; $display("FAIL b2b_third count %0d head %h exp 1 %h", cnt32, imm64, ref_imm(c, 3'd4));
    end
    in_valid = 1'b0;
    tick();
    n_checks++;
    if (v32 !== 1'b0 || imm32 !== 32'd0 || imm64 !== 64'd0 || fmt32 !== 3'd0 || cnt64 !== 2'd0) begin
      n_fail++; $display("FAIL b2b_drain v %b imm %h fmt %0d exp empty zeros", v32, imm64, fmt32);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] prev;
    logic [2:0]  psrc;
    out_ready = 1'b0; in_valid = 1'b1;
    prev = $urandom; psrc = 3'd3;
    instruction = prev; imm_src = psrc;
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      instruction = $urandom; imm_src = 3'($urandom_range(1, 6));
      n_checks++;
      if (imm64 !== ref_imm(prev, psrc)) begin
        n_fail++; $display("FAIL wrap_head_%0d got %h exp %h", i, imm64, ref_imm(prev, psrc));
      end
      prev = instruction; psrc = imm_src;
      tick();
      n_checks++;
      if (cnt32 !== 2'd1 || cnt64 !== 2'd1) begin
        n_fail++; $display("FAIL wrap_count_%0d got %0d exp 1", i, cnt32);
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_random();
    logic exp_v;
    for (int i = 0; i < 400; i++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      out_ready   = ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
      instruction = $urandom;
      imm_src     = 3'($urandom_range(0, 7));
      exp_v = (mq.size() != 0);
      n_checks++;
      if (v32 !== exp_v || v64 !== exp_v || cnt32 !== 2'(mq.size()) || cnt64 !== 2'(mq.size())) begin
        n_fail++; $display("FAIL rand_occ_%0d v %b cnt %0d exp %b %0d", i, v32, cnt32, exp_v, mq.size());
      end
      n_checks++;
      if (rdy32 !== (mq.size() != DEPTH) || rdy64 !== (mq.size() != DEPTH)) begin
        n_fail++; $display("FAIL rand_in_ready_%0d got %b exp %b", i, rdy32, mq.size() != DEPTH);
      end
      n_checks++;
      if (imm64 !== e_imm() || imm32 !== e_imm()[31:0] || fmt32 !== e_fmt() || fmt64 !== e_fmt()) begin
        n_fail++; $display("FAIL rand_head_%0d imm %h/%h fmt %0d exp %h %0d", i, imm32, imm64, fmt32, e_imm(), e_fmt());
      end
`ifdef IMMGEN_ERR_CHECK_EN
      n_checks++;
      if (err32 !== (exp_v && mq[0].err) || err64 !== (exp_v && mq[0].err)) begin
        n_fail++; $display("FAIL rand_err_%0d got %b exp %b", i, err32, exp_v && mq[0].err);
      end
`endif
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; in_valid = 1'b1; imm_src = 3'd5;
    instruction = $urandom; tick();
    instruction = $urandom; tick();
    in_valid = 1'b0;
    n_checks++;
    if (cnt32 !== 2'd2) begin
      n_fail++; $display("FAIL mid_prefill count %0d exp 2", cnt32);
    end
    #2 reset = 1'b1;
    mq.delete(); mrdy = 1'b0;
    #1;
    n_checks++;
    if (v32 !== 1'b0 || v64 !== 1'b0 || imm32 !== 32'd0 || imm64 !== 64'd0 || cnt32 !== 2'd0 || cnt64 !== 2'd0) begin
      n_fail++; $display("FAIL mid_reset v %b imm %h cnt %0d exp 0 0 0", v32, imm64, cnt32);
    end
    @(negedge clk);
    reset = 1'b0;
    tick();
    instruction = 32'hFFF00093; imm_src = 3'b001; in_valid = 1'b1;
    tick();
    n_checks++;
    if (v32 !== 1'b1 || imm32 !== 32'hFFFFFFFF || imm64 !== 64'hFFFFFFFFFFFFFFFF || fmt32 !== 3'b001) begin
      n_fail++; $display("FAIL mid_first_push v %b imm %h fmt %0d exp 1 ffffffff 1", v32, imm32, fmt32);
    end
    instruction = $urandom; imm_src = 3'b111; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    n_checks++;
    if (v32 !== 1'b1 || imm32 !== 32'd0 || imm64 !== 64'd0 || fmt64 !== 3'b111 || cnt32 !== 2'd1) begin
      n_fail++; $display("FAIL mid_src7 v %b imm %h fmt %0d cnt %0d exp 1 0 7 1", v32, imm64, fmt64, cnt32);
    end
`ifdef IMMGEN_ERR_CHECK_EN
    n_checks++;
    if (err32 !== 1'b1 || err64 !== 1'b1) begin
      n_fail++; $display("FAIL mid_err got %b/%b exp 1", err32, err64);
    end
`endif
    out_ready = 1'b1;
    tick();
`ifdef IMMGEN_ERR_CHECK_EN
    n_checks++;
    if (err32 !== 1'b0 || v32 !== 1'b0) begin
      n_fail++; $display("FAIL empty_err got %b v %b exp 0 0", err32, v32);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
